systolic_arr_ctrl: RTL and testbench

- Sequencer that runs one N x N systolic matrix multiply, C = A x W, over inner dimension K.
- Takes ownership of the four operand RAMs (W0/W1/A0/A1) from the UART FSM.
- Issues skewed per-lane read addresses and gates RAM data into the array with zero insertion.
- Drives the per-PE mult/accum enables and clears, then pulses done and returns RAM ownership.

---
 rtl/sys_arr_pkg.sv | 21 ++
 rtl/systolic_win_gen.sv | 34 +++
 rtl/systolic_arr_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_systolic_arr_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_arr_pkg.sv
// Shared definitions for the systolic array controller: default geometry,
// controller state encoding and lane/PE container types.
package sys_arr_pkg;

    localparam int DEF_N      = 2;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } ctrl_state_t;

    // One fp32 lane word and the per-PE mask, for the default geometry.
    typedef logic [DEF_DATA_W-1:0]      lane_data_t;
    typedef logic [DEF_N*DEF_N-1:0]     pe_mask_t;

endpackage

// File: rtl/systolic_win_gen.sv
// PE window generator: PE [i][j] is enabled for k_len cycles starting at
// global cycle OFFSET+i+j, which reproduces the diagonal wavefront of the
// skewed operand streams. Bit i*N+j of mask_o belongs to PE [i][j].
module systolic_win_gen
    import sys_arr_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_ADDR_W + 4,
    parameter int OFFSET = 1
) (
    input  logic              run_i,
    input  logic [CNT_W-1:0]  g_i,
    input  logic [ADDR_W-1:0] k_len_i,
    output logic [N*N-1:0]    mask_o
);

    // Per-PE window compare: OFFSET+i+j <= g < OFFSET+i+j+k_len.
    always_comb begin
        mask_o = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (run_i
                    && (g_i >= CNT_W'(OFFSET + i + j))
                    && (g_i <  CNT_W'(OFFSET + i + j) + CNT_W'(k_len_i))) begin
                    mask_o[i*N+j] = 1'b1;
                end else begin
                    mask_o[i*N+j] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/systolic_arr_ctrl.sv
// Systolic array sequencer: runs one N x N multiply C = A x W over inner
// dimension k_len. It owns the operand RAMs for the duration of the run,
// issues skewed per-lane reads, gates RAM data into the array with zeros
// outside the valid window, drives the PE mult/accum enables and clears,
// and pulses done at the end.
// Optional: define SYS_ARR_CTRL_PERF_EN to build the run-length counter on
// perf_cycles; otherwise perf_cycles is constant zero.
module systolic_arr_ctrl
    import sys_arr_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RD_LAT   = 1,
    parameter int MULT_LAT = 1,
    parameter int ACC_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   k_len,
    input  logic [ADDR_W-1:0]   a_base,
    input  logic [ADDR_W-1:0]   w_base,
    output logic                ram_own,
    output logic [N*ADDR_W-1:0] ram_a_addr,
    output logic [N*ADDR_W-1:0] ram_w_addr,
    output logic [N-1:0]        ram_a_rden,
    output logic [N-1:0]        ram_w_rden,
    input  logic [N*DATA_W-1:0] ram_a_q,
    input  logic [N*DATA_W-1:0] ram_w_q,
    output logic [N*DATA_W-1:0] a_in,
    output logic [N*DATA_W-1:0] w_in,
    output logic [N*N-1:0]      en_mult,
    output logic [N*N-1:0]      clr_mult,
    output logic [N*N-1:0]      en_accum,
    output logic [N*N-1:0]      clr_accum,
    output logic                busy,
    output logic                done,
    output logic [15:0]         perf_cycles
);

    // Counter headroom: g reaches k_len plus the pipeline tail.
    localparam int CNT_W      = ADDR_W + 4;
    // g offset past k_len at which the last accumulation has settled.
    localparam int DRAIN_TAIL = RD_LAT + MULT_LAT + 2*(N-1) + ACC_LAT - 1;

    ctrl_state_t              state_q, state_d;
    logic [CNT_W-1:0]         g_q, g_d;
    logic [ADDR_W-1:0]        k_len_q, k_len_d;
    logic [ADDR_W-1:0]        a_base_q, a_base_d;
    logic [ADDR_W-1:0]        w_base_q, w_base_d;
    logic [N*ADDR_W-1:0]      a_hold_q, w_hold_q;
    logic [RD_LAT-1:0][N-1:0] act_dly_q;

    logic                     accept_s;
    logic                     run_s;
    logic [N-1:0]             act_s;
    logic [CNT_W-1:0]         feed_last_s;
    logic [CNT_W-1:0]         drain_last_s;

    assign accept_s     = (state_q == IDLE) && start;
    assign run_s        = (state_q == FEED) || (state_q == DRAIN);
    // While feeding, the stream counter t is the same as g.
    assign feed_last_s  = CNT_W'(k_len_q) + CNT_W'(N) - CNT_W'(2);
    assign drain_last_s = CNT_W'(k_len_q) + CNT_W'(DRAIN_TAIL);

    // Next-state logic: sequencing, stream counter and start-time operand latch.
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        k_len_d  = k_len_q;
        a_base_d = a_base_q;
        w_base_d = w_base_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CLR;
                    k_len_d  = k_len;
                    a_base_d = a_base;
                    w_base_d = w_base;
                end else begin
                    state_d  = IDLE;
                end
            end
            CLR: begin
                g_d = '0;
                if (k_len_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = FEED;
                end
            end
            FEED: begin
                g_d = g_q + CNT_W'(1);
                if (g_q == feed_last_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = FEED;
                end
            end
            DRAIN: begin
                g_d = g_q + CNT_W'(1);
                if (g_q == drain_last_s) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                g_d     = '0;
                state_d = IDLE;
            end
            default: begin
                g_d     = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            g_q      <= '0;
            k_len_q  <= '0;
            a_base_q <= '0;
            w_base_q <= '0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            k_len_q  <= k_len_d;
            a_base_q <= a_base_d;
            w_base_q <= w_base_d;
        end
    end

    // Lane i reads during FEED while i <= t <= i+k_len-1.
    always_comb begin
        act_s = '0;
        for (int i = 0; i < N; i++) begin
            if ((state_q == FEED)
                && (g_q >= CNT_W'(i))
                && ((g_q - CNT_W'(i)) < CNT_W'(k_len_q))) begin
                act_s[i] = 1'b1;
            end else begin
                act_s[i] = 1'b0;
            end
        end
    end

    // Per-lane addresses: base+(t-i) while active (wrapping), else hold last value.
    always_comb begin
        ram_a_addr = a_hold_q;
        ram_w_addr = w_hold_q;
        for (int i = 0; i < N; i++) begin
            if (act_s[i]) begin
                ram_a_addr[i*ADDR_W +: ADDR_W] = a_base_q + ADDR_W'(g_q - CNT_W'(i));
                ram_w_addr[i*ADDR_W +: ADDR_W] = w_base_q + ADDR_W'(g_q - CNT_W'(i));
            end else begin
                ram_a_addr[i*ADDR_W +: ADDR_W] = a_hold_q[i*ADDR_W +: ADDR_W];
                ram_w_addr[i*ADDR_W +: ADDR_W] = w_hold_q[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign ram_a_rden = act_s;
    assign ram_w_rden = act_s;

    // Address hold registers and RD_LAT-deep lane-active delay line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_hold_q  <= '0;
            w_hold_q  <= '0;
            act_dly_q <= '0;
        end else begin
            a_hold_q     <= ram_a_addr;
            w_hold_q     <= ram_w_addr;
            act_dly_q[0] <= act_s;
            for (int k = 1; k < RD_LAT; k++) begin
                act_dly_q[k] <= act_dly_q[k-1];
            end
        end
    end

    // Pass RAM data into the array only when it answers an active read.
    always_comb begin
        a_in = '0;
        w_in = '0;
        for (int i = 0; i < N; i++) begin
            if (act_dly_q[RD_LAT-1][i]) begin
                a_in[i*DATA_W +: DATA_W] = ram_a_q[i*DATA_W +: DATA_W];
                w_in[i*DATA_W +: DATA_W] = ram_w_q[i*DATA_W +: DATA_W];
            end else begin
                a_in[i*DATA_W +: DATA_W] = '0;
                w_in[i*DATA_W +: DATA_W] = '0;
            end
        end
    end

    systolic_win_gen #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .OFFSET (RD_LAT)
    ) u_win_mult (
        .run_i   (run_s),
        .g_i     (g_q),
        .k_len_i (k_len_q),
        .mask_o  (en_mult)
    );

    systolic_win_gen #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .OFFSET (RD_LAT + MULT_LAT)
    ) u_win_accum (
        .run_i   (run_s),
        .g_i     (g_q),
        .k_len_i (k_len_q),
        .mask_o  (en_accum)
    );

    // Clears only exist in CLR, so they can never coincide with an enable.
    assign clr_mult  = {(N*N){state_q == CLR}};
    assign clr_accum = {(N*N){state_q == CLR}};

    // Busy/ownership rise in the accepting cycle and cover the done cycle.
    assign busy    = (state_q != IDLE) || accept_s;
    assign ram_own = busy;
    assign done    = (state_q == DONE);

`ifdef SYS_ARR_CTRL_PERF_EN
    logic [15:0] perf_q, perf_d;

    // Run-length counter: the accepting cycle counts as 1, frozen from done on.
    always_comb begin
        perf_d = perf_q;
        if (accept_s) begin
            perf_d = 16'd1;
        end else if ((state_q != IDLE) && (state_q != DONE)) begin
            if (perf_q != 16'hFFFF) begin
                perf_d = perf_q + 16'd1;
            end else begin
                perf_d = perf_q;
            end
        end else begin
            perf_d = perf_q;
        end
    end

    // Run-length counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= 16'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_systolic_arr_ctrl.sv
// Scoreboard bench for systolic_arr_ctrl. Stimulus issues runs and pushes a
// run descriptor; a negedge monitor derives every expected output from the
// descriptor with plain arithmetic and compares.
module tb_systolic_arr_ctrl;
    import sys_arr_pkg::*;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 32;

    typedef struct {
        int start_cyc;
        int k;
        int ab;
        int wb;
    } run_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [AW-1:0]     k_len, a_base, w_base;
    logic              ram_own, busy, done;
    logic [N*AW-1:0]   ram_a_addr, ram_w_addr;
    logic [N-1:0]      ram_a_rden, ram_w_rden;
    logic [N*DW-1:0]   ram_a_q = '0;
    logic [N*DW-1:0]   ram_w_q = '0;
    logic [N*DW-1:0]   a_in, w_in;
    logic [N*N-1:0]    en_mult, clr_mult, en_accum, clr_accum;
    logic [15:0]       perf_cycles;

    logic [DW-1:0]     mem_a [N][256];
    logic [DW-1:0]     mem_w [N][256];
    run_t              runq [$];
    int                cyc = 0;
    logic              rst_at_edge = 1'b0;
    int                checks = 0;
    int                errors = 0;

    systolic_arr_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .k_len       (k_len),
        .a_base      (a_base),
        .w_base      (w_base),
        .ram_own     (ram_own),
        .ram_a_addr  (ram_a_addr),
        .ram_w_addr  (ram_w_addr),
        .ram_a_rden  (ram_a_rden),
        .ram_w_rden  (ram_w_rden),
        .ram_a_q     (ram_a_q),
        .ram_w_q     (ram_w_q),
        .a_in        (a_in),
        .w_in        (w_in),
        .en_mult     (en_mult),
        .clr_mult    (clr_mult),
        .en_accum    (en_accum),
        .clr_accum   (clr_accum),
        .busy        (busy),
        .done        (done),
        .perf_cycles (perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_at_edge <= rst_n;

    // Operand RAMs with one cycle of read latency; q holds when not read.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (ram_a_rden[i]) ram_a_q[i*DW +: DW] <= mem_a[i][ram_a_addr[i*AW +: AW]];
            if (ram_w_rden[i]) ram_w_q[i*DW +: DW] <= mem_w[i][ram_w_addr[i*AW +: AW]];
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit lane_on(input int g, input int i, input int k);
        return (g >= i) && (g <= i + k - 1);
    endfunction

    // Monitor / scoreboard: expected outputs from the head-of-queue run.
    initial begin : monitor
        run_t            r;
        int              rel, g, tot, k, perf_hold;
        bit              pop;
        logic            e_busy, e_done, e_clr;
        logic [N-1:0]    e_rden;
        logic [N*AW-1:0] hold_a, hold_w;
        logic [N*DW-1:0] e_ain, e_win;
        logic [N*N-1:0]  e_em, e_ea;
        logic [15:0]     e_perf;
        hold_a = '0; hold_w = '0; perf_hold = 0; tot = 0;
        forever begin
            @(negedge clk);
            e_busy = 1'b0; e_done = 1'b0; e_clr = 1'b0; e_rden = '0;
            e_ain = '0; e_win = '0; e_em = '0; e_ea = '0; pop = 1'b0;
            e_perf = 16'(perf_hold);
            if (!rst_at_edge) begin
                runq.delete();
                hold_a = '0; hold_w = '0; perf_hold = 0; e_perf = 16'd0;
            end else if (runq.size() > 0) begin
                r   = runq[0];
                k   = r.k;
                rel = cyc - r.start_cyc;
                tot = (k == 0) ? 2 : k + 7;
                g   = rel - 2;
                e_busy = 1'b1;
                e_done = (rel == tot);
                e_clr  = (rel == 1);
                for (int i = 0; i < N; i++) begin
                    if (lane_on(g, i, k)) begin
                        e_rden[i] = 1'b1;
                        hold_a[i*AW +: AW] = AW'(r.ab + g - i);
                        hold_w[i*AW +: AW] = AW'(r.wb + g - i);
                    end
                    if (lane_on(g - 1, i, k)) begin
                        e_ain[i*DW +: DW] = mem_a[i][AW'(r.ab + g - 1 - i)];
                        e_win[i*DW +: DW] = mem_w[i][AW'(r.wb + g - 1 - i)];
                    end
                    for (int j = 0; j < N; j++) begin
                        if (g >= 1 + i + j && g <= i + j + k) e_em[i*N+j] = 1'b1;
                        if (g >= 2 + i + j && g <= 1 + i + j + k) e_ea[i*N+j] = 1'b1;
                    end
                end
                if (rel > 0) e_perf = 16'(rel);
                pop = e_done;
            end
`ifndef SYS_ARR_CTRL_PERF_EN
            e_perf = 16'd0;
`endif
            chk("busy",      256'(busy),       256'(e_busy));
            chk("ram_own",   256'(ram_own),    256'(e_busy));
            chk("done",      256'(done),       256'(e_done));
            chk("clr",       256'({clr_mult, clr_accum}), 256'({2*N*N{e_clr}}));
            chk("rden",      256'({ram_a_rden, ram_w_rden}), 256'({e_rden, e_rden}));
            chk("addr",      256'({ram_a_addr, ram_w_addr}), 256'({hold_a, hold_w}));
            chk("a_in",      256'(a_in),       256'(e_ain));
            chk("w_in",      256'(w_in),       256'(e_win));
            chk("en_mult",   256'(en_mult),    256'(e_em));
            chk("en_accum",  256'(en_accum),   256'(e_ea));
            chk("perf",      256'(perf_cycles), 256'(e_perf));
            if (pop) begin
                void'(runq.pop_front());
                perf_hold = tot;
            end
        end
    end

    task automatic fill_rand();
        for (int i = 0; i < N; i++)
            for (int a = 0; a < 256; a++) begin
                mem_a[i][a] = $urandom;
                mem_w[i][a] = $urandom;
            end
    endtask

    task automatic fill_const(input lane_data_t v);
        for (int i = 0; i < N; i++)
            for (int a = 0; a < 256; a++) begin
                mem_a[i][a] = v;
                mem_w[i][a] = v;
            end
    endtask

    // One run: start, optional ignored second start, optional mid-run reset.
    task automatic do_run(input int k, input int ab, input int wb,
                          input int dup_at, input int rst_at);
        run_t r;
        int   n, tot, dones;
        bit   got;
        @(posedge clk); #1;
        k_len = AW'(k); a_base = AW'(ab); w_base = AW'(wb); start = 1'b1;
        r.start_cyc = cyc; r.k = k; r.ab = ab; r.wb = wb;
        runq.push_back(r);
        tot = (k == 0) ? 2 : k + 7;
        n = 0; got = 1'b0;
        while (1) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (rst_at >= 0 && n > rst_at + 1) break;
            if (n >= 400) begin
                checks++; errors++;
                $display("FAIL timeout: no done after %0d cycles, required at %0d", n, tot);
                break;
            end
            @(posedge clk); #1;
            n++;
            start = (n == dup_at) ? 1'b1 : 1'b0;
            rst_n = (n == rst_at) ? 1'b0 : 1'b1;
        end
        start = 1'b0;
        rst_n = 1'b1;
        if (rst_at >= 0) begin
            chk("abandoned_done", 256'(got), 256'(0));
            dones = 0;
            repeat (12) begin
                @(negedge clk);
                if (done === 1'b1) dones++;
            end
            chk("post_reset_dones", 256'(dones), 256'(0));
        end else begin
            chk("latency", 256'(got ? n : -1), 256'(tot));
        end
    endtask

    // Stimulus sequence.
    initial begin : stim
        rst_n = 1'b0; start = 1'b0; k_len = '0; a_base = '0; w_base = '0;
        fill_rand();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        do_run(4, 'h10, 'h20, -1, -1);                 // nominal
        do_run(0, 'h33, 'h44, -1, -1);                 // empty inner dimension
        do_run(4, 'hFE, 'hFF, -1, -1);                 // address wrap
        do_run(4, $urandom_range(0, 255), $urandom_range(0, 255), 4, -1);  // start while busy
        fill_const(32'h3F80_0000);
        do_run(4, 'h40, 'h80, -1, -1);                 // zero insertion
        fill_rand();
        do_run(4, 'h10, 'h20, -1, 5);                  // reset at g=3
        do_run(3, 'h05, 'h06, -1, -1);                 // clean run after reset
        for (int r = 0; r < 10; r++) begin
            fill_rand();
            do_run($urandom_range(0, 12), $urandom_range(0, 255), $urandom_range(0, 255),
                   ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : -1, -1);
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
